// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack imem fetch FSM and a prefetch queue feeding decode.
// Optional macro IF_ACK_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_wpcir,
    input  logic        id_branch,
    input  logic [31:0] id_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);
    localparam int PW = (FQ_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam int NSLOT = 1 << PW;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DROP} state_t;

    state_t          state_q, state_d;
    logic            req_q;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     drop_pc_q, drop_pc_d;
    logic [3:0]      tag_q, tag_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fq_inst_q [0:NSLOT-1];
    logic [31:0]     fq_pc4_q  [0:NSLOT-1];
    logic [3:0]      fq_tag_q  [0:NSLOT-1];

    logic pop, take, push, byp_hit, byp_pop, launch_ok;
    logic [31:0] head_inst, head_pc4;
    logic [3:0]  head_tag, ins_type;

    always_comb begin
        pop  = (count_q != '0) && !id_wpcir && !id_branch;
        take = (state_q == ST_REQ) && imem_ack && !id_branch;
`ifdef IF_ACK_BYPASS_EN
        byp_hit = take && (count_q == '0);
        byp_pop = byp_hit && !id_wpcir;
`else
        byp_hit = 1'b0;
        byp_pop = 1'b0;
`endif
        push = take && !byp_pop;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (id_branch) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = (wr_ptr_q == PW'(FQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // A new request is only issued if its word is guaranteed a free slot.
        launch_ok = (count_d < CW'(FQ_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_pc_d  = drop_pc_q;
        tag_d      = tag_q;
        if (take) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_d      = tag_q + 4'd1;
        end
        if (id_branch) fetch_pc_d = id_new_pc & ~32'd3;
        case (state_q)
            ST_IDLE: state_d = launch_ok ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = launch_ok ? ST_REQ : ST_IDLE;
                end else if (id_branch) begin
                    state_d   = ST_DROP;
                    drop_pc_d = fetch_pc_q;
                end
            end
            ST_DROP: if (imem_ack) state_d = launch_ok ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        addr_d = (state_d == ST_DROP) ? drop_pc_d : fetch_pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            drop_pc_q  <= '0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d != ST_IDLE);
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            drop_pc_q  <= drop_pc_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload needs no reset: count_q alone decides whether an entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_inst_q[wr_ptr_q] <= imem_rdata;
            fq_pc4_q[wr_ptr_q]  <= fetch_pc_q + 32'd4;
            fq_tag_q[wr_ptr_q]  <= tag_q;
        end
    end

    always_comb begin
        head_inst = '0;
        head_pc4  = '0;
        head_tag  = '0;
        if (byp_hit) begin
            head_inst = imem_rdata;
            head_pc4  = fetch_pc_q + 32'd4;
            head_tag  = tag_q;
        end else if (count_q != '0) begin
            head_inst = fq_inst_q[rd_ptr_q];
            head_pc4  = fq_pc4_q[rd_ptr_q];
            head_tag  = fq_tag_q[rd_ptr_q];
        end
    end

    always_comb begin
        casez (head_inst[31:26])
            6'b000000: ins_type = (head_inst[5:0] == 6'b001000) ? 4'd2 : 4'd1;
            6'b001???: ins_type = 4'd3;
            6'b100011: ins_type = 4'd4;
            6'b101011: ins_type = 4'd5;
            6'b00010?: ins_type = 4'd6;
            6'b00001?: ins_type = 4'd7;
            default:   ins_type = 4'd8;
        endcase
        if (head_inst == 32'h0) ins_type = 4'd0;
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign if_inst       = head_inst;
    assign if_pc4        = head_pc4;
    assign IF_ins_type   = ins_type;
    assign IF_ins_number = head_tag;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: zero/delayed-wait memory model, stall, redirect, tag wrap, reset.
// Inputs change at the falling edge; outputs are checked at the falling edge before inputs change.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_wpcir = 1'b0;
    logic        id_branch = 1'b0;
    logic [31:0] id_new_pc = 32'h0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, if_inst, if_pc4;
    logic [3:0]  IF_ins_type, IF_ins_number;
    logic        ack_en = 1'b1;
    logic [31:0] mem [0:63];
    logic [3:0]  typ [0:63];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [71:0] got_h, exp_h;
    logic [32:0] got_a, exp_a;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem[imem_addr[7:2]];
    assign got_h      = {if_inst, if_pc4, IF_ins_type, IF_ins_number};
    assign got_a      = {imem_req, imem_addr};

    if_fetch_stage #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .id_wpcir(id_wpcir), .id_branch(id_branch), .id_new_pc(id_new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_inst(if_inst), .if_pc4(if_pc4), .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number)
    );

    task automatic init_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h2000_0000 | i;
            typ[i] = 4'd3;
        end
        mem[0]  = 32'h2008_0005; typ[0]  = 4'd3;
        mem[1]  = 32'h8C09_0000; typ[1]  = 4'd4;
        mem[2]  = 32'hAC09_0004; typ[2]  = 4'd5;
        mem[3]  = 32'h0128_5020; typ[3]  = 4'd1;
        mem[4]  = 32'hDEAD_0010; typ[4]  = 4'd8;
        mem[16] = 32'h3C01_1234; typ[16] = 4'd3;
        mem[17] = 32'hBEEF_0044; typ[17] = 4'd8;
        mem[32] = 32'h2008_0005; typ[32] = 4'd3;
        mem[33] = 32'h8C09_0000; typ[33] = 4'd4;
        mem[34] = 32'hAC09_0004; typ[34] = 4'd5;
        mem[35] = 32'h0128_5020; typ[35] = 4'd1;
        mem[36] = 32'h03E0_0008; typ[36] = 4'd2;
        mem[37] = 32'h1000_FFFF; typ[37] = 4'd6;
        mem[38] = 32'h1420_0002; typ[38] = 4'd6;
        mem[39] = 32'h0C00_0010; typ[39] = 4'd7;
        mem[40] = 32'h0000_0000; typ[40] = 4'd0;
        mem[41] = 32'h3C01_1234; typ[41] = 4'd3;
        mem[42] = 32'h0800_0000; typ[42] = 4'd7;
        mem[43] = 32'h4000_0000; typ[43] = 4'd8;
        mem[44] = 32'h8000_0000; typ[44] = 4'd8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL reset_head: got %h want %h", got_h, 72'h0); end
        tests_run++; if (got_a !== 33'h0) begin tests_failed++; $display("FAIL reset_req: got %h want %h", got_a, 33'h0); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        exp_a = {1'b1, 32'h0};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL fetch_first_req: got %h want %h", got_a, exp_a); end
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL fetch_bubble: got %h want %h", got_h, 72'h0); end
        @(negedge clk);
        exp_h = {32'h2008_0005, 32'h4, 4'd3, 4'd0};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL fetch_word0: got %h want %h", got_h, exp_h); end
        @(negedge clk);
        exp_h = {32'h8C09_0000, 32'h8, 4'd4, 4'd1};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL fetch_word1: got %h want %h", got_h, exp_h); end
        exp_a = {1'b1, 32'h8};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL fetch_addr8: got %h want %h", got_a, exp_a); end
    endtask

    task automatic test_stall();
        id_wpcir = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_h = {32'h8C09_0000, 32'h8, 4'd4, 4'd1};
            tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL stall_hold%0d: got %h want %h", c, got_h, exp_h); end
            tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req%0d: got %b want 0", c, imem_req); end
        end
        id_wpcir = 1'b0;
        @(negedge clk);
        exp_h = {32'hAC09_0004, 32'hC, 4'd5, 4'd2};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL stall_pop1: got %h want %h", got_h, exp_h); end
        exp_a = {1'b1, 32'hC};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL stall_relaunch: got %h want %h", got_a, exp_a); end
        @(negedge clk);
        exp_h = {32'h0128_5020, 32'h10, 4'd1, 4'd3};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL stall_pop2: got %h want %h", got_h, exp_h); end
    endtask

    task automatic test_redirect_drop();
        ack_en = 1'b0;
        @(negedge clk);
        exp_a = {1'b1, 32'h10};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL drop_pending: got %h want %h", got_a, exp_a); end
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL drop_empty: got %h want %h", got_h, 72'h0); end
        id_branch = 1'b1;
        id_new_pc = 32'h43;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            id_branch = 1'b0;
            tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL drop_hold%0d: got %h want %h", c, got_a, exp_a); end
            tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL drop_bubble%0d: got %h want %h", c, got_h, 72'h0); end
        end
        ack_en = 1'b1;
        @(negedge clk);
        exp_a = {1'b1, 32'h40};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL drop_newreq: got %h want %h", got_a, exp_a); end
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL drop_discard: got %h want %h", got_h, 72'h0); end
        @(negedge clk);
        exp_h = {32'h3C01_1234, 32'h44, 4'd3, 4'd4};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL drop_target: got %h want %h", got_h, exp_h); end
    endtask

    task automatic test_redirect_ack();
        id_branch = 1'b1;
        id_new_pc = 32'h80;
        @(negedge clk);
        id_branch = 1'b0;
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL racc_flush: got %h want %h", got_h, 72'h0); end
        exp_a = {1'b1, 32'h80};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL racc_req: got %h want %h", got_a, exp_a); end
        @(negedge clk);
        exp_h = {32'h2008_0005, 32'h84, 4'd3, 4'd5};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL racc_tag: got %h want %h", got_h, exp_h); end
    endtask

    task automatic test_wrap();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_h = {mem[32 + k], 32'h84 + 32'(4 * k), typ[32 + k], 4'(5 + k)};
            tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL wrap_k%0d: got %h want %h", k, got_h, exp_h); end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL rstmid_head: got %h want %h", got_h, 72'h0); end
        tests_run++; if (got_a !== 33'h0) begin tests_failed++; $display("FAIL rstmid_req: got %h want %h", got_a, 33'h0); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_a = {1'b1, 32'h0};
        tests_run++; if (got_a !== exp_a) begin tests_failed++; $display("FAIL rstmid_refetch: got %h want %h", got_a, exp_a); end
        @(negedge clk);
        exp_h = {32'h2008_0005, 32'h4, 4'd3, 4'd0};
        tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL rstmid_word0: got %h want %h", got_h, exp_h); end
    endtask

`ifdef IF_ACK_BYPASS_EN
    task automatic test_bypass();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_h = {mem[k], 32'(4 * k + 4), typ[k], 4'(k)};
            tests_run++; if (got_h !== exp_h) begin tests_failed++; $display("FAIL bypass_k%0d: got %h want %h", k, got_h, exp_h); end
        end
        rst = 1'b1;
        #1;
        tests_run++; if (got_h !== 72'h0) begin tests_failed++; $display("FAIL bypass_rst: got %h want %h", got_h, 72'h0); end
        tests_run++; if (got_a !== 33'h0) begin tests_failed++; $display("FAIL bypass_rst_req: got %h want %h", got_a, 33'h0); end
    endtask
`endif

    initial begin
        init_mem();
        test_reset();
`ifdef IF_ACK_BYPASS_EN
        test_bypass();
`else
        test_fetch();
        test_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
